// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the sequential integer square-root engine.
package sqrt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } sqrt_state_e;

  // Clock cycles spent in CALC: each cycle retires 2*steps_per_cycle radicand bits.
  function automatic int sqrt_iter(input int in_w, input int steps_per_cycle);
    return in_w / (2 * steps_per_cycle);
  endfunction

  function automatic int sqrt_cnt_w(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root recurrence step: folds two radicand bits into the
// partial remainder and decides the next root bit.
module sqrt_step #(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W+1:0] rem_in,
  input  logic [OUT_W-1:0] root_in,
  input  logic [1:0]       bits,
  output logic [OUT_W+1:0] rem_out,
  output logic [OUT_W-1:0] root_out
);

  logic [OUT_W+3:0] rem_shift;
  logic [OUT_W+3:0] trial;
  logic [OUT_W+3:0] diff;
  logic             take;

  always_comb begin
    rem_shift = {rem_in, bits};
    trial     = {2'b00, root_in, 2'b01};
    diff      = rem_shift - trial;
    take      = (rem_shift >= trial);
    rem_out   = take ? diff[OUT_W+1:0] : rem_shift[OUT_W+1:0];
    root_out  = {root_in[OUT_W-2:0], take};
  end

endmodule

// File: rtl/sqrt_calculator_gen2.sv
// Multi-cycle integer square root (floor root plus remainder) behind a start/done handshake.
// Define SQRT_ROUND_EN to round the reported root to nearest instead of flooring it.
module sqrt_calculator_gen2
  import sqrt_pkg::*;
#(
  parameter  int IN_W            = 16,
  parameter  int SIGNED_IN       = 1,
  parameter  int STEPS_PER_CYCLE = 1,
  localparam int OUT_W           = IN_W / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W:0]   rem,
  output logic             error,
  output logic             busy,
  output logic             done,
  output sqrt_state_e      state
);

  localparam int ITER  = sqrt_iter(IN_W, STEPS_PER_CYCLE);
  localparam int CNT_W = sqrt_cnt_w(ITER);

  // Handshake: a request is taken when start is high in IDLE outside the done
  // cycle; in is captured on that edge only. done pulses one cycle with the
  // result, and busy covers every cycle from after the accept through done.

  sqrt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [IN_W-1:0]  rad_q;
  logic [OUT_W-1:0] root_q;
  logic [OUT_W+1:0] rem_q;
  logic             neg_q;
  logic             accept;
  logic             neg_in;
  logic [OUT_W-1:0] out_fin;

  logic [OUT_W+1:0] rem_c  [STEPS_PER_CYCLE+1];
  logic [OUT_W-1:0] root_c [STEPS_PER_CYCLE+1];

  assign neg_in = (SIGNED_IN != 0) && in[IN_W-1];
  assign accept = (state_q == S_IDLE) && start && !done;
  assign busy   = (state_q != S_IDLE) || done;
  assign state  = state_q;

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    sqrt_step #(.OUT_W(OUT_W)) u_step (
      .rem_in  (rem_c[i]),
      .root_in (root_c[i]),
      .bits    (rad_q[IN_W-1-2*i -: 2]),
      .rem_out (rem_c[i+1]),
      .root_out(root_c[i+1])
    );
  end

`ifdef SQRT_ROUND_EN
  // rem_floor > root_floor means in is past (root+0.5)^2; saturate at all-ones.
  logic round_up;
  assign round_up = (rem_q > {2'b00, root_q}) && (root_q != {OUT_W{1'b1}});
  assign out_fin  = root_q + OUT_W'(round_up);
`else
  assign out_fin  = root_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = neg_in ? S_FIN : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      neg_q  <= 1'b0;
      out    <= '0;
      rem    <= '0;
      error  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rad_q  <= in;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= neg_in;
          end
        end
        S_CALC: begin
          rad_q  <= rad_q << (2 * STEPS_PER_CYCLE);
          root_q <= root_c[STEPS_PER_CYCLE];
          rem_q  <= rem_c[STEPS_PER_CYCLE];
          cnt_q  <= cnt_q + 1'b1;
        end
        S_FIN: begin
          done  <= 1'b1;
          error <= neg_q;
          out   <= neg_q ? '0 : out_fin;
          rem   <= neg_q ? '0 : (OUT_W+1)'(rem_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_calculator_gen2.sv
// Directed bench for sqrt_calculator_gen2: three instances (signed/1 step, unsigned/1 step,
// unsigned/2 steps), a vector table plus hand sequences for abort, ignored starts and timing.
module tb_sqrt_calculator_gen2;
  import sqrt_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst   [N];
  logic        start [N];
  logic [15:0] din   [N];
  logic [7:0]  out   [N];
  logic [8:0]  rem   [N];
  logic        error [N];
  logic        busy  [N];
  logic        done  [N];
  sqrt_state_e state [N];

  int checks   = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int SG  = (g == 0) ? 1 : 0;
    localparam int SPC = (g == 2) ? 2 : 1;
    sqrt_calculator_gen2 #(
      .IN_W(16), .SIGNED_IN(SG), .STEPS_PER_CYCLE(SPC)
    ) u_dut (
      .clk  (clk),
      .rst  (rst[g]),
      .start(start[g]),
      .in   (din[g]),
      .out  (out[g]),
      .rem  (rem[g]),
      .error(error[g]),
      .busy (busy[g]),
      .done (done[g]),
      .state(state[g])
    );
  end

  typedef struct {
    int          dev;
    logic [15:0] value;
    logic [7:0]  out_floor;
    logic [7:0]  out_round;
    logic [8:0]  rem;
    logic        err;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pick_out(input logic [7:0] fl, input logic [7:0] rd);
`ifdef SQRT_ROUND_EN
    return rd;
`else
    return fl;
`endif
  endfunction

  // Waits for done (counting from `elapsed` cycles after accept) and scores the result.
  task automatic wait_done(input int d, input int e_lat, input int elapsed, input bit poke,
                           input string tag);
    int          lat = 0;
    bit          got = 1'b0;
    logic [17:0] e;
    for (int c = elapsed + 1; c <= elapsed + 40 && !got; c++) begin
      @(posedge clk); #1;
      if (done[d]) begin
        lat = c;
        got = 1'b1;
      end
    end
    check({tag, " latency"}, lat, e_lat);
    e = exp_q.pop_front();
    if (got) begin
      check({tag, " out"},   out[d],   e[16:9]);
      check({tag, " rem"},   rem[d],   e[8:0]);
      check({tag, " error"}, error[d], e[17]);
      check({tag, " busy in done"}, busy[d], 1);
      if (poke) begin
        @(negedge clk); start[d] = 1'b1; din[d] = 16'd16;
      end
      @(posedge clk); #1;
      start[d] = 1'b0;
      check({tag, " done pulse"}, done[d], 0);
      check({tag, " idle after"}, busy[d], 0);
      check({tag, " out held"},   out[d],  e[16:9]);
    end
  endtask

  task automatic launch(input int d, input logic [15:0] v, input logic [7:0] e_out,
                        input logic [8:0] e_rem, input logic e_err, input string tag);
    exp_q.push_back({e_err, e_out, e_rem});
    @(negedge clk);
    start[d] = 1'b1;
    din[d]   = v;
    @(posedge clk); #1;
    start[d] = 1'b0;
    din[d]   = 16'($urandom_range(0, 65535));
    check({tag, " busy after accept"}, busy[d], 1);
  endtask

  task automatic run_req(input int d, input logic [15:0] v, input logic [7:0] e_out,
                         input logic [8:0] e_rem, input logic e_err, input int e_lat,
                         input string tag);
    launch(d, v, e_out, e_rem, e_err, tag);
    wait_done(d, e_lat, 0, 1'b0, tag);
  endtask

  // Abort an in-flight request and confirm it leaves no trace.
  task automatic abort_seq(input int d, input string tag);
    int seen = 0;
    @(negedge clk); start[d] = 1'b1; din[d] = 16'd400;
    @(posedge clk); #1; start[d] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst[d] = 1'b1;
    @(posedge clk); #1;
    check({tag, " out"},   out[d],   0);
    check({tag, " rem"},   rem[d],   0);
    check({tag, " error"}, error[d], 0);
    check({tag, " busy"},  busy[d],  0);
    check({tag, " state"}, state[d], S_IDLE);
    @(negedge clk); rst[d] = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done[d]) seen++;
    end
    check({tag, " no done"}, seen, 0);
  endtask

  vec_t vecs[16];

  initial begin
    int extra;
    vecs[0]  = '{0, 16'd16,    8'd4,   8'd4,   9'd0,   1'b0, 9};
    vecs[1]  = '{0, 16'd18,    8'd4,   8'd4,   9'd2,   1'b0, 9};
    vecs[2]  = '{0, 16'd24,    8'd4,   8'd5,   9'd8,   1'b0, 9};
    vecs[3]  = '{0, 16'hFFF6,  8'd0,   8'd0,   9'd0,   1'b1, 1};
    vecs[4]  = '{0, 16'd32767, 8'd181, 8'd181, 9'd6,   1'b0, 9};
    vecs[5]  = '{0, 16'h8000,  8'd0,   8'd0,   9'd0,   1'b1, 1};
    vecs[6]  = '{0, 16'd1,     8'd1,   8'd1,   9'd0,   1'b0, 9};
    vecs[7]  = '{1, 16'd65535, 8'd255, 8'd255, 9'd510, 1'b0, 9};
    vecs[8]  = '{1, 16'd0,     8'd0,   8'd0,   9'd0,   1'b0, 9};
    vecs[9]  = '{1, 16'd99,    8'd9,   8'd10,  9'd18,  1'b0, 9};
    vecs[10] = '{1, 16'd3,     8'd1,   8'd2,   9'd2,   1'b0, 9};
    vecs[11] = '{1, 16'hFFF6,  8'd255, 8'd255, 9'd501, 1'b0, 9};
    vecs[12] = '{2, 16'd255,   8'd15,  8'd16,  9'd30,  1'b0, 5};
    vecs[13] = '{2, 16'd100,   8'd10,  8'd10,  9'd0,   1'b0, 5};
    vecs[14] = '{2, 16'd65535, 8'd255, 8'd255, 9'd510, 1'b0, 5};
    vecs[15] = '{2, 16'd2,     8'd1,   8'd1,   9'd1,   1'b0, 5};

    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; din[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("reset out d%0d", d),   out[d],   0);
      check($sformatf("reset rem d%0d", d),   rem[d],   0);
      check($sformatf("reset error d%0d", d), error[d], 0);
      check($sformatf("reset busy d%0d", d),  busy[d],  0);
      check($sformatf("reset done d%0d", d),  done[d],  0);
      check($sformatf("reset state d%0d", d), state[d], S_IDLE);
    end
    @(negedge clk);
    for (int d = 0; d < N; d++) rst[d] = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_req(vecs[i].dev, vecs[i].value, pick_out(vecs[i].out_floor, vecs[i].out_round),
              vecs[i].rem, vecs[i].err, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Second start three cycles into CALC must be dropped.
    launch(1, 16'd200, 8'd14, 9'd4, 1'b0, "busy start");
    repeat (2) @(posedge clk);
    @(negedge clk); start[1] = 1'b1; din[1] = 16'd100;
    @(posedge clk); #1; start[1] = 1'b0;
    wait_done(1, 9, 3, 1'b0, "busy start");
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done[1] || busy[1]) extra++;
    end
    check("busy start not queued", extra, 0);

    // Start raised during the done cycle must not be accepted.
    launch(0, 16'd49, 8'd7, 9'd0, 1'b0, "done start");
    wait_done(0, 9, 0, 1'b1, "done start");
    check("done start state", state[0], S_IDLE);

    abort_seq(0, "abort d0");
    run_req(0, 16'd25, 8'd5, 9'd0, 1'b0, 9, "after abort d0");
    abort_seq(2, "abort d2");
    run_req(2, 16'd25, 8'd5, 9'd0, 1'b0, 5, "after abort d2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
